arb2_stream_merge: RTL and testbench

ARB2_STREAM_MERGE -- requirements
Module: arb2_stream_merge

---
 rtl/arb2_stream_merge.sv | 68 ++++++
 tb/tb_arb2_stream_merge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/arb2_stream_merge.sv
// rtl/arb2_stream_merge.sv - two-channel round-robin valid/ready merge into a single output register
module arb2_stream_merge #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             a0_valid,
  input  logic [WIDTH-1:0] a0_data,
  output logic             a0_ready,
  input  logic             a1_valid,
  input  logic [WIDTH-1:0] a1_data,
  output logic             a1_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             s,
  input  logic             y_ready
);

  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;

  pri_t pri, pri_nxt;
  logic load, grant0, grant1, acc0, acc1;

  // Readies are gated by clrn so nothing is offered while reset is held.
  always_comb begin
    load    = !y_valid | y_ready;
    grant0  = a0_valid & (!a1_valid | (pri == PRI0));
    grant1  = a1_valid & (!a0_valid | (pri == PRI1));
    acc0    = clrn & load & grant0;
    acc1    = clrn & load & grant1;
    pri_nxt = pri;
    if (acc0) begin
      pri_nxt = PRI1;
    end else if (acc1) begin
      pri_nxt = PRI0;
    end
  end

  assign a0_ready = acc0;
  assign a1_ready = acc1;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pri <= PRI0;
    end else begin
      pri <= pri_nxt;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      s       <= 1'b0;
    end else if (acc0) begin
      y_valid <= 1'b1;
      y_data  <= a0_data;
      s       <= 1'b0;
    end else if (acc1) begin
      y_valid <= 1'b1;
      y_data  <= a1_data;
      s       <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb2_stream_merge.sv
// tb/tb_arb2_stream_merge.sv - scoreboard bench for arb2_stream_merge
module tb_arb2_stream_merge;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         a0_valid = 1'b0, a1_valid = 1'b0, y_ready = 1'b0;
  logic [W-1:0] a0_data = '0, a1_data = '0;
  logic         a0_ready, a1_ready, y_valid, s;
  logic [W-1:0] y_data;

  arb2_stream_merge #(.WIDTH(W)) dut (
    .clk(clk), .clrn(clrn),
    .a0_valid(a0_valid), .a0_data(a0_data), .a0_ready(a0_ready),
    .a1_valid(a1_valid), .a1_data(a1_data), .a1_ready(a1_ready),
    .y_valid(y_valid), .y_data(y_data), .s(s), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         s;
  } item_t;

  item_t exp_q[$];
  item_t log_q[$];
  item_t ref_q[$];
  int    log_cyc[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic  m_yv = 1'b0, m_pri = 1'b0, m_acc0 = 1'b0, m_acc1 = 1'b0;
  bit    rand_phase = 1'b0;
  int    nseq0 = 0, nseq1 = 0, seq0 = 0, seq1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: a word leaves whenever y_valid and y_ready meet at the coming edge.
  always @(negedge clk) begin
    if (clrn === 1'b1 && y_valid === 1'b1 && y_ready === 1'b1) begin
      item_t got, e;
      got.d = y_data;
      got.s = s;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", y_data, e.d);
        chk("out_s", W'(s), W'(e.s));
      end
      if (rand_phase) begin
        if (s) begin
          chk("ch1_order", y_data, 32'h8000_0000 | W'(nseq1));
          nseq1++;
        end else begin
          chk("ch0_order", y_data, W'(nseq0));
          nseq0++;
        end
      end else begin
        log_q.push_back(got);
        log_cyc.push_back(cyc);
      end
    end
  end

  // Drives one cycle of inputs and predicts readies/accepts from the arbitration rules.
  task automatic apply(input logic v0, input logic [W-1:0] d0, input logic v1,
                       input logic [W-1:0] d1, input logic yr);
    logic  load, r0, r1;
    item_t it;
    a0_valid = v0; a0_data = d0; a1_valid = v1; a1_data = d1; y_ready = yr;
    load = !m_yv | yr;
    r0 = load & v0 & (!v1 | !m_pri);
    r1 = load & v1 & (!v0 | m_pri);
    #1;
    chk("a0_ready", W'(a0_ready), W'(r0));
    chk("a1_ready", W'(a1_ready), W'(r1));
    chk("ready_exclusive", W'(a0_ready & a1_ready), 32'd0);
    m_acc0 = r0;
    m_acc1 = r1;
    if (r0) begin
      it.d = d0; it.s = 1'b0; exp_q.push_back(it); m_yv = 1'b1; m_pri = 1'b1;
    end else if (r1) begin
      it.d = d1; it.s = 1'b1; exp_q.push_back(it); m_yv = 1'b1; m_pri = 1'b0;
    end else if (yr) begin
      m_yv = 1'b0;
    end
  endtask

  task automatic step(input logic v0, input logic [W-1:0] d0, input logic v1,
                      input logic [W-1:0] d1, input logic yr);
    @(posedge clk);
    #2;
    apply(v0, d0, v1, d1, yr);
  endtask

  task automatic add_ref(input logic [W-1:0] d, input logic s_i);
    item_t it;
    it.d = d;
    it.s = s_i;
    ref_q.push_back(it);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, W'(log_q.size()), W'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < log_q.size(); i++) begin
      chk({name, "_data"}, log_q[i].d, ref_q[i].d);
      chk({name, "_s"}, W'(log_q[i].s), W'(ref_q[i].s));
      if (i > 0) chk({name, "_gap"}, W'(log_cyc[i] - log_cyc[i-1]), 32'd1);
    end
    log_q.delete();
    log_cyc.delete();
    ref_q.delete();
  endtask

  initial begin
    a0_valid = 1'b1; a1_valid = 1'b1; a0_data = 32'h11; a1_data = 32'h22; y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_y_valid", W'(y_valid), 32'd0);
    chk("rst_y_data", y_data, 32'd0);
    chk("rst_s", W'(s), 32'd0);
    chk("rst_a0_ready", W'(a0_ready), 32'd0);
    chk("rst_a1_ready", W'(a1_ready), 32'd0);

    // Alternation from a fresh release; first edge with clrn high accepts.
    @(posedge clk);
    #2;
    clrn = 1'b1;
    apply(1, 32'h11, 1, 32'h22, 1);
    repeat (5) step(1, 32'h11, 1, 32'h22, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add_ref(32'h11, 1'b0);
      add_ref(32'h22, 1'b1);
    end
    check_log("alternate");

    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'hA0 + W'(i), 1);
    step(1, 32'hB0, 1, 32'hB1, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add_ref(32'hA0 + W'(i), 1'b1);
    add_ref(32'hB0, 1'b0);
    check_log("single_chan");

    step(1, 32'h55, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h56, 1, 32'h66, 0);
      chk("stall_y_valid", W'(y_valid), 32'd1);
      chk("stall_y_data", y_data, 32'h55);
      chk("stall_s", W'(s), 32'd0);
    end
    step(1, 32'h56, 1, 32'h66, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    add_ref(32'h55, 1'b0);
    add_ref(32'h66, 1'b1);
    check_log("backpressure");

    step(1, 32'h7, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("drain_valid_hi", W'(y_valid), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("drain_valid_lo", W'(y_valid), 32'd0);
    step(0, 0, 0, 0, 1);
    chk("drain_valid_stays_lo", W'(y_valid), 32'd0);
    add_ref(32'h7, 1'b0);
    check_log("drain");

    // Mid-transfer reset: the held word is discarded and PRI0 rules resume.
    step(1, 32'hC0, 1, 32'hC1, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_y_valid", W'(y_valid), 32'd1);
    #3;
    clrn = 1'b0;
    #1;
    chk("async_rst_y_valid", W'(y_valid), 32'd0);
    chk("async_rst_y_data", y_data, 32'd0);
    chk("async_rst_s", W'(s), 32'd0);
    chk("async_rst_a0_ready", W'(a0_ready), 32'd0);
    chk("async_rst_a1_ready", W'(a1_ready), 32'd0);
    exp_q.delete();
    m_yv = 1'b0;
    m_pri = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2;
    clrn = 1'b1;
    apply(1, 32'hD0, 1, 32'hD1, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    add_ref(32'hD0, 1'b0);
    check_log("reset_release");

    rand_phase = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), W'(seq0), 1'($urandom_range(0, 1)),
           32'h8000_0000 | W'(seq1), 1'($urandom_range(0, 1)));
      if (m_acc0) seq0++;
      if (m_acc1) seq1++;
    end
    repeat (3) step(0, 0, 0, 0, 1);
    chk("rand_ch0_count", W'(nseq0), W'(seq0));
    chk("rand_ch1_count", W'(nseq1), W'(seq1));
    chk("rand_queue_empty", W'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
